// File: rtl/qpsk_frame_deframer.sv
// Purpose : hunts a 2-bit QPSK symbol stream for a sync word, then packs
//           PAYLOAD_BYTES payload bytes (4 symbols per byte, MSB-first).
// Latency : byte_valid rises 1 cycle after the 4th symbol of a byte is presented.
// Backpr. : single-entry output slot; a completed byte with the slot still full and
//           not draining is dropped and flagged on overflow / overflow_sticky.
//
// Ports:
//   CLOCK_256       system clock, rising edge
//   reset           synchronous, active-high
//   sym_valid       sym_in carries a symbol this cycle
//   sym_in[1:0]     demodulated symbol (demod_bits[1:0])
//   byte_out[7:0]   assembled payload byte
//   byte_valid      byte_out holds an unconsumed byte
//   byte_ready      consumer takes byte_out when byte_valid && byte_ready
//   frame_start     1-cycle pulse: sync word detected
//   frame_done      1-cycle pulse: last payload symbol received
//   overflow        1-cycle pulse: completed byte dropped
//   overflow_sticky set by any overflow, cleared only by reset
module qpsk_frame_deframer #(
  parameter logic [7:0]  SYNC_WORD     = 8'hA5,
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic       CLOCK_256,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       overflow,
  output logic       overflow_sticky
);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  // Index of the final payload byte, compared against the pre-increment count.
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  state_t     state;
  state_t     state_nxt;

  // Only the six most recent bits need storing; the newest symbol is
  // concatenated combinationally to form the full 8-bit candidate.
  logic [5:0] sync_sr;
  logic [2:0] hunt_cnt;
  logic [5:0] asm_sr;
  logic [1:0] sym_cnt;
  logic [7:0] byte_cnt;

  logic [7:0] sync_cand;
  logic [7:0] byte_cand;

  logic       sync_hit;
  logic       byte_cmpl;
  logic       last_byte;
  logic       byte_load;
  logic       byte_drop;
  logic       drain;

  assign sync_cand = {sync_sr, sym_in};
  assign byte_cand = {asm_sr, sym_in};

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge CLOCK_256) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (sync_hit) begin
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (last_byte) begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // ------------------------------------------------------------------
  // Output / control decode
  // ------------------------------------------------------------------
  always_comb begin
    sync_hit  = 1'b0;
    byte_cmpl = 1'b0;
    last_byte = 1'b0;
    byte_load = 1'b0;
    byte_drop = 1'b0;
    drain     = byte_valid && byte_ready;
    case (state)
      HUNT: begin
        // hunt_cnt >= 3 means at least three symbols precede this one since
        // entering HUNT, so a cleared shift register can never fake a match.
        sync_hit = sym_valid && (sync_cand == SYNC_WORD) && (hunt_cnt >= 3'd3);
      end
      PAYLOAD: begin
        byte_cmpl = sym_valid && (sym_cnt == 2'd3);
        last_byte = byte_cmpl && (byte_cnt == LAST_IDX);
        // The slot is free if empty or being drained at this very edge.
        byte_load = byte_cmpl && (!byte_valid || byte_ready);
        byte_drop = byte_cmpl && byte_valid && !byte_ready;
      end
      default: begin
        sync_hit = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Sync hunting datapath
  // ------------------------------------------------------------------
  always_ff @(posedge CLOCK_256) begin
    if (reset) begin
      sync_sr  <= '0;
      hunt_cnt <= '0;
    end else if (state == HUNT) begin
      if (sym_valid) begin
        sync_sr <= sync_cand[5:0];
        if (hunt_cnt != 3'd4) begin
          hunt_cnt <= hunt_cnt + 3'd1;
        end
      end
    end else if (last_byte) begin
      // Fresh hunt after each frame: no reuse of pre-frame history.
      sync_sr  <= '0;
      hunt_cnt <= '0;
    end
  end

  // ------------------------------------------------------------------
  // Payload assembly datapath
  // ------------------------------------------------------------------
  always_ff @(posedge CLOCK_256) begin
    if (reset) begin
      asm_sr   <= '0;
      sym_cnt  <= '0;
      byte_cnt <= '0;
    end else if (sync_hit) begin
      sym_cnt  <= '0;
      byte_cnt <= '0;
    end else if ((state == PAYLOAD) && sym_valid) begin
      asm_sr  <= byte_cand[5:0];
      sym_cnt <= sym_cnt + 2'd1;
      // Counts delivered and dropped bytes alike so frame length is fixed.
      if (byte_cmpl) begin
        byte_cnt <= byte_cnt + 8'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Output slot and status pulses
  // ------------------------------------------------------------------
  always_ff @(posedge CLOCK_256) begin
    if (reset) begin
      byte_out        <= '0;
      byte_valid      <= 1'b0;
      frame_start     <= 1'b0;
      frame_done      <= 1'b0;
      overflow        <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      frame_start <= sync_hit;
      frame_done  <= last_byte;
      overflow    <= byte_drop;
      if (byte_drop) begin
        overflow_sticky <= 1'b1;
      end
      if (byte_load) begin
        // Covers load-and-drain in one cycle: new byte replaces the old one.
        byte_out   <= byte_cand;
        byte_valid <= 1'b1;
      end else if (drain) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/qpsk_frame_deframer.md
Name: qpsk_frame_deframer

Overview:
- Sits directly downstream of the QPSK demodulator and consumes one 2-bit symbol per valid cycle, taken from the low two bits of the demodulator's 4-bit output.
- Hunts the symbol stream for a sync word, then packs a fixed number of payload bytes (4 symbols per byte, MSB-first).
- Presents completed bytes on a valid/ready interface to the downstream byte consumer (UART/packet stage).
- Reports frame start, frame end and overflow.

Parameters:
- SYNC_WORD, 8'hA5, sync pattern. Compared MSB-first; first symbol received = bits [7:6].
- PAYLOAD_BYTES, 4, number of payload bytes per frame. Range 1..255.

Ports:
- CLOCK_256  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sym_valid  input  1  sym_in is valid this cycle.
- sym_in  input  2  demodulated symbol (demod_bits[1:0]).
- byte_out  output  8  assembled payload byte.
- byte_valid  output  1  byte_out holds an unconsumed byte.
- byte_ready  input  1  consumer accepts byte_out when byte_valid && byte_ready.
- frame_start  output  1  one-cycle pulse: sync word detected.
- frame_done  output  1  one-cycle pulse: last payload symbol received.
- overflow  output  1  one-cycle pulse: completed byte dropped.
- overflow_sticky  output  1  set by any overflow; cleared only by reset.

Behaviour:
- Reset, sampled synchronously at a rising edge of CLOCK_256:
  - state=HUNT.
  - sync shift register, hunt count, symbol count, byte count and assembly register all cleared.
  - byte_out=0, byte_valid=0, frame_start=0, frame_done=0, overflow=0, overflow_sticky=0.
  - Reset mid-frame discards partial bytes and any pending byte_out.
- sym_valid=0: no change to state, counters or shift/assembly registers. Output handshake still operates.
- State HUNT:
  - Each valid symbol: sr <= {sr[5:0], sym_in}; hunt_cnt increments, saturating at 4.
  - Match condition: {sr[5:0], sym_in} == SYNC_WORD and hunt_cnt >= 3 (i.e. at least 4 symbols since entering HUNT).
  - On match, at the same edge: state <= PAYLOAD, frame_start <= 1 for one cycle, symbol and byte counters cleared.
  - Overlapping patterns are detected: the shift register is continuous, so there is no skip after a near-miss.
- State PAYLOAD:
  - Each valid symbol: asm <= {asm[5:0], sym_in}; sym_cnt (2-bit) increments and wraps.
  - On the 4th symbol (sym_cnt==3), the byte is complete: value {asm[5:0], sym_in}.
    - If byte_valid==0, or byte_valid && byte_ready this cycle: byte_out <= byte, byte_valid <= 1.
    - Otherwise: byte dropped, byte_out unchanged, overflow <= 1 for one cycle, overflow_sticky <= 1.
  - byte_cnt increments on every completed byte, whether delivered or dropped.
  - When the completed byte is number PAYLOAD_BYTES: frame_done <= 1 for one cycle, state <= HUNT, sr and hunt_cnt cleared.
- Latency: byte_valid rises at the same edge that samples the 4th symbol, so it is visible 1 cycle after that symbol is presented.
- Output handshake:
  - byte_valid && byte_ready at an edge with no new byte loaded: byte_valid <= 0.
  - While byte_valid && !byte_ready, byte_out is held stable.
  - Load and drain in the same cycle: new byte replaces old, byte_valid stays 1, no overflow.
- Pulse outputs (frame_start, frame_done, overflow) are 0 in every cycle not listed above.
- Counter widths: byte_cnt is 8 bits, hunt_cnt is 3 bits.

Test Plan:
- Reset, then symbols 10,10,01,01 (0xA5), then 00,11,11,00 ×4 with byte_ready=1.
  - frame_start pulses at the edge of the 4th sync symbol.
  - Four bytes 0x3C appear, each byte_valid 1 cycle after the byte's last symbol.
  - frame_done pulses with the 16th payload symbol; state returns to HUNT.
- Noise 11,10,10,10,01,01 (sync embedded after a near-miss) -> frame_start after symbol 6; no byte_valid before sync.
- byte_ready=0 throughout a frame with bytes 0x11,0x22,0x33,0x44.
  - byte_out=0x11 is held with byte_valid=1.
  - overflow pulses 3 times; overflow_sticky=1.
  - frame_done still pulses.
- byte_ready asserted exactly in the cycle the second byte completes -> second byte loaded, byte_valid stays 1, overflow=0.
- sym_valid gapped (1 of every 3 cycles) across sync and payload -> identical byte values and pulse counts as the gap-free case.
- Assert reset after 6 payload symbols -> all outputs 0 the next cycle; a fresh sync plus 4 bytes then deframes correctly.
